// File: rtl/id_branch_stage.sv
// IF/ID pipeline register with ID-stage control-flow resolution (beq, bne, j, jal, jr).
// A taken redirect squashes the wrong-path fetch; a hazard stall holds the register and defers the branch.
module id_branch_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instruction_F,
    input  logic [31:0]      PcPlus4_F,
    input  logic             stall_D,
    input  logic [31:0]      rs_data_D,
    input  logic [31:0]      rt_data_D,
    output logic [31:0]      Instruction_D,
    output logic [31:0]      PcPlus4_D,
    output logic             valid_D,
    output logic [4:0]       rs_addr_D,
    output logic [4:0]       rt_addr_D,
    output logic             branch,
    output logic [31:0]      pc_branch,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [31:0]      br_offset;
    logic             taken;
    logic [31:0]      target;
    logic             branch_w;

    assign op        = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = 32'd0;
        case (op)
            OP_BEQ: begin
                taken  = (rs_data_D == rt_data_D);
                target = pc4_q + br_offset;
            end
            OP_BNE: begin
                taken  = (rs_data_D != rt_data_D);
                target = pc4_q + br_offset;
            end
            OP_J, OP_JAL: begin
                taken  = 1'b1;
                target = {pc4_q[31:28], instr_q[25:0], 2'b00};
            end
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    taken  = 1'b1;
                    target = rs_data_D;
                end
            end
            default: begin
                taken  = 1'b0;
                target = 32'd0;
            end
        endcase
    end

    // valid_D marks a real instruction in ID; branch is a one-cycle request that
    // fetch must obey at the next edge, and is held off while stall_D is high.
    assign branch_w = taken & valid_q & ~stall_D;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        bcnt_d  = bcnt_q;
        scnt_d  = scnt_q;
        if (branch_w) begin
            instr_d = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!stall_D) begin
            instr_d = Instruction_F;
            pc4_d   = PcPlus4_F;
            valid_d = 1'b1;
        end
        if (branch_w && (bcnt_q != CNT_MAX)) begin
            bcnt_d = bcnt_q + CNT_W'(1);
        end
        if (stall_D && valid_q && (scnt_q != CNT_MAX)) begin
            scnt_d = scnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            bcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            bcnt_q  <= bcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    assign Instruction_D = instr_q;
    assign PcPlus4_D     = pc4_q;
    assign valid_D       = valid_q;
    assign rs_addr_D     = instr_q[25:21];
    assign rt_addr_D     = instr_q[20:16];
    assign branch        = branch_w;
    assign pc_branch     = branch_w ? target : 32'd0;
    assign branch_count  = bcnt_q;
    assign stall_count   = scnt_q;

endmodule

// File: tb/tb_id_branch_stage.sv
// Directed bench for id_branch_stage: one default-width instance and one CNT_W=2 instance
// share stimulus; the driver queues hand-computed expectations, a negedge monitor checks them.
module tb_id_branch_stage;

    localparam int EW = 134;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction_F;
    logic [31:0] PcPlus4_F;
    logic        stall_D;
    logic [31:0] rs_data_D;
    logic [31:0] rt_data_D;

    logic [31:0] instr_a, pc4_a, pcb_a;
    logic        valid_a, br_a;
    logic [4:0]  rsa_a, rta_a;
    logic [15:0] bcnt_a, scnt_a;

    logic [31:0] instr_b, pc4_b, pcb_b;
    logic        valid_b, br_b;
    logic [4:0]  rsa_b, rta_b;
    logic [1:0]  bcnt_b, scnt_b;

    logic [EW-1:0] exp_q[$];
    int n_cmp;
    int n_fail;
    logic [15:0] m_bcnt;
    logic [15:0] m_scnt;

    localparam logic [31:0] I_ADDI = 32'h2008_0005;
    localparam logic [31:0] I_BEQ  = 32'h1109_FFFE;
    localparam logic [31:0] I_BNE  = 32'h1509_FFFE;
    localparam logic [31:0] I_J    = 32'h0800_0040;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_ADD  = 32'h0109_5020;

    id_branch_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .Instruction_F(Instruction_F), .PcPlus4_F(PcPlus4_F),
        .stall_D(stall_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
        .Instruction_D(instr_a), .PcPlus4_D(pc4_a), .valid_D(valid_a),
        .rs_addr_D(rsa_a), .rt_addr_D(rta_a), .branch(br_a), .pc_branch(pcb_a),
        .branch_count(bcnt_a), .stall_count(scnt_a)
    );

    id_branch_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .Instruction_F(Instruction_F), .PcPlus4_F(PcPlus4_F),
        .stall_D(stall_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
        .Instruction_D(instr_b), .PcPlus4_D(pc4_b), .valid_D(valid_b),
        .rs_addr_D(rsa_b), .rt_addr_D(rta_b), .branch(br_b), .pc_branch(pcb_b),
        .branch_count(bcnt_b), .stall_count(scnt_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] sat2(input logic [15:0] v);
        return (v > 16'd3) ? 2'd3 : v[1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: one call per clock cycle; expectations describe the state seen in that cycle
    task automatic cyc(input logic r, input logic [31:0] fi, input logic [31:0] fpc,
                       input logic st, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                       input logic eb, input logic [31:0] epb);
        @(posedge clk);
        #1;
        rst           = r;
        Instruction_F = fi;
        PcPlus4_F     = fpc;
        stall_D       = st;
        rs_data_D     = rs;
        rt_data_D     = rt;
        if (r) begin
            m_bcnt = 16'd0;
            m_scnt = 16'd0;
        end
        exp_q.push_back({ei, ep, ev, eb, epb, m_bcnt, m_scnt, sat2(m_bcnt), sat2(m_scnt)});
        if (!r) begin
            if (eb)        m_bcnt = m_bcnt + 16'd1;
            if (st && ev)  m_scnt = m_scnt + 16'd1;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instr",      instr_a,                 e[133:102]);
            chk("pc4",        pc4_a,                   e[101:70]);
            chk("valid",      {31'd0, valid_a},        {31'd0, e[69]});
            chk("branch",     {31'd0, br_a},           {31'd0, e[68]});
            chk("pc_branch",  pcb_a,                   e[67:36]);
            chk("rs_addr",    {27'd0, rsa_a},          {27'd0, e[127:123]});
            chk("rt_addr",    {27'd0, rta_a},          {27'd0, e[122:118]});
            chk("branch_cnt", {16'd0, bcnt_a},         {16'd0, e[35:20]});
            chk("stall_cnt",  {16'd0, scnt_a},         {16'd0, e[19:4]});
            chk("s_instr",    instr_b,                 e[133:102]);
            chk("s_branch",   {31'd0, br_b},           {31'd0, e[68]});
            chk("s_pc_branch", pcb_b,                  e[67:36]);
            chk("s_misc",     {pc4_b[15:0], 4'd0, valid_b, rsa_b, rta_b, 1'b0},
                              {e[85:70], 4'd0, e[69], e[127:123], e[122:118], 1'b0});
            chk("s_branch_cnt", {30'd0, bcnt_b},       {30'd0, e[3:2]});
            chk("s_stall_cnt",  {30'd0, scnt_b},       {30'd0, e[1:0]});
        end
    end

    initial begin
        int wait_cycles;
        n_cmp  = 0;
        n_fail = 0;
        m_bcnt = 16'd0;
        m_scnt = 16'd0;
        rst           = 1'b1;
        Instruction_F = 32'd0;
        PcPlus4_F     = 32'd0;
        stall_D       = 1'b0;
        rs_data_D     = 32'd0;
        rt_data_D     = 32'd0;

        // reset and release, first fetch loads
        cyc(1, I_ADDI, 32'h4,   0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, I_ADDI, 32'h4,   0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, I_BEQ,  32'h100, 0, 0, 0,  I_ADDI, 32'h4, 1, 0, 0);
        // beq taken, squash, beq not taken
        cyc(0, 32'hDEADBEEF, 32'h104, 0, 7, 7,  I_BEQ, 32'h100, 1, 1, 32'h0000_00F8);
        cyc(0, I_BEQ,  32'h100, 0, 7, 8,  0, 0, 0, 0, 0);
        cyc(0, I_BNE,  32'h200, 0, 7, 8,  I_BEQ, 32'h100, 1, 0, 0);
        // bne taken when unequal, not taken when equal
        cyc(0, 32'h1111_1111, 32'h204, 0, 7, 8,  I_BNE, 32'h200, 1, 1, 32'h0000_01F8);
        cyc(0, I_BNE,  32'h300, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, I_J,    32'hF000_0010, 0, 5, 5,  I_BNE, 32'h300, 1, 0, 0);
        // j keeps upper PC nibble; jr goes to rs
        cyc(0, 32'h2222_2222, 32'hF000_0014, 0, 0, 0,  I_J, 32'hF000_0010, 1, 1, 32'hF000_0100);
        cyc(0, I_JR,   32'h400, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 32'h3333_3333, 32'h404, 0, 32'h0040_0020, 0,  I_JR, 32'h400, 1, 1, 32'h0040_0020);
        cyc(0, I_BEQ,  32'h100, 0, 0, 0,  0, 0, 0, 0, 0);
        // taken beq under a 3-cycle stall, then released
        cyc(0, 32'h4444_4444, 32'h104, 1, 7, 7,  I_BEQ, 32'h100, 1, 0, 0);
        cyc(0, 32'h4444_4444, 32'h104, 1, 7, 7,  I_BEQ, 32'h100, 1, 0, 0);
        cyc(0, 32'h4444_4444, 32'h104, 1, 7, 7,  I_BEQ, 32'h100, 1, 0, 0);
        cyc(0, 32'h4444_4444, 32'h104, 0, 7, 7,  I_BEQ, 32'h100, 1, 1, 32'h0000_00F8);
        // stall on a squashed slot holds the bubble and is not counted
        cyc(0, I_ADD,  32'h500, 1, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, I_ADD,  32'h500, 0, 0, 0,  0, 0, 0, 0, 0);
        // R-type with non-jr funct is not taken
        cyc(0, I_J,    32'hF000_0010, 0, 0, 0,  I_ADD, 32'h500, 1, 0, 0);
        cyc(0, 32'h5555_5555, 32'hF000_0014, 0, 0, 0,  I_J, 32'hF000_0010, 1, 1, 32'hF000_0100);
        cyc(0, I_ADDI, 32'h4,   0, 0, 0,  0, 0, 0, 0, 0);
        // asynchronous reset right after a real load
        cyc(1, I_ADDI, 32'h4,   0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, I_ADDI, 32'h4,   0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 32'h0,  32'h0,   0, 0, 0,  I_ADDI, 32'h4, 1, 0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        n_cmp++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
